// File: rtl/rs_alloc_tracker.sv
// Reservation-station occupancy tracker (ALU/CF/AGU): busy bits, per-class free counts, next-free ids.
// Latency: alloc/release/flush visible one cycle later; next ids are combinational from registered state.
// Backpressure: none internal; a class with no free station reports id NUM_ST so the decoder stalls.
// Optional build macro RS_RR_ALLOC_EN: round-robin next-id selection per class instead of lowest-index.
module rs_alloc_tracker #(
   parameter int NUM_ALU = 4,
   parameter int NUM_CF  = 2,
   parameter int NUM_AGU = 4,
   parameter int NUM_ST  = NUM_ALU + NUM_CF + NUM_AGU,
   parameter int ID_W    = $clog2(NUM_ST + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         alloc_valid,
   input  logic [ID_W-1:0]              alloc_id,
   input  logic [NUM_ST-1:0]            release_mask,
   input  logic                         flush,
   output logic [NUM_ST-1:0]            available,
   output logic [ID_W-1:0]              alu_next_id,
   output logic [ID_W-1:0]              cf_next_id,
   output logic [ID_W-1:0]              agu_next_id,
   output logic [$clog2(NUM_ALU+1)-1:0] alu_free_cnt,
   output logic [$clog2(NUM_CF+1)-1:0]  cf_free_cnt,
   output logic [$clog2(NUM_AGU+1)-1:0] agu_free_cnt,
   output logic                         alloc_err
);

   localparam int ALU_CW   = $clog2(NUM_ALU + 1);
   localparam int CF_CW    = $clog2(NUM_CF + 1);
   localparam int AGU_CW   = $clog2(NUM_AGU + 1);
   localparam int CF_BASE  = NUM_ALU;
   localparam int AGU_BASE = NUM_ALU + NUM_CF;
   localparam logic [ID_W-1:0] ST_ID = ID_W'(NUM_ST);

   logic [NUM_ST-1:0] busy;
   logic [NUM_ST-1:0] busy_nxt;
   logic [NUM_ST-1:0] rel_ok;
   logic              rel_bad;
   logic              alloc_ok;
   logic              alloc_bad;
   logic              a_alu, a_cf, a_agu;
   int                aid;
   int                rel_alu, rel_cf, rel_agu;
   logic [ALU_CW-1:0] alu_cnt_nxt;
   logic [CF_CW-1:0]  cf_cnt_nxt;
   logic [AGU_CW-1:0] agu_cnt_nxt;
   int                alu_start, cf_start, agu_start;

   // First free station in [base, base+size), searching circularly from local offset start.
   function automatic logic [ID_W-1:0] pick(input logic [NUM_ST-1:0] fr, input int base,
                                            input int size, input int start);
      logic [ID_W-1:0] r;
      int              j;
      r = ST_ID;
      for (int k = size - 1; k >= 0; k--) begin
         j = start + k;
         if (j >= size) j = j - size;
         if (fr[base+j]) r = ID_W'(base + j);
      end
      return r;
   endfunction

`ifdef RS_RR_ALLOC_EN
   logic [ID_W-1:0] alu_ptr, cf_ptr, agu_ptr;
   logic [ID_W-1:0] alu_ptr_nxt, cf_ptr_nxt, agu_ptr_nxt;

   // Pointer moves to the station after the one just allocated, wrapping inside its class.
   always_comb begin
      alu_ptr_nxt = alu_ptr;
      cf_ptr_nxt  = cf_ptr;
      agu_ptr_nxt = agu_ptr;
      if (a_alu) alu_ptr_nxt = ID_W'((aid + 1 >= NUM_ALU) ? 0 : aid + 1);
      if (a_cf)  cf_ptr_nxt  = ID_W'((aid - CF_BASE + 1 >= NUM_CF) ? 0 : aid - CF_BASE + 1);
      if (a_agu) agu_ptr_nxt = ID_W'((aid - AGU_BASE + 1 >= NUM_AGU) ? 0 : aid - AGU_BASE + 1);
   end

   // Round-robin pointers; reset and flush return them to the first station of each class.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_ptr <= '0;
         cf_ptr  <= '0;
         agu_ptr <= '0;
      end else if (flush) begin
         alu_ptr <= '0;
         cf_ptr  <= '0;
         agu_ptr <= '0;
      end else begin
         alu_ptr <= alu_ptr_nxt;
         cf_ptr  <= cf_ptr_nxt;
         agu_ptr <= agu_ptr_nxt;
      end
   end

   assign alu_start = int'(alu_ptr);
   assign cf_start  = int'(cf_ptr);
   assign agu_start = int'(agu_ptr);
`else
   assign alu_start = 0;
   assign cf_start  = 0;
   assign agu_start = 0;
`endif

   // Legality checks and next busy/count state; release is applied before alloc.
   always_comb begin
      rel_ok    = release_mask & busy;
      rel_bad   = |(release_mask & ~busy);
      aid       = int'(alloc_id);
      alloc_ok  = 1'b0;
      alloc_bad = 1'b0;
      if (alloc_valid) begin
         if (alloc_id >= ST_ID)
            alloc_bad = 1'b1;
         else if (busy[alloc_id] && !release_mask[alloc_id])
            alloc_bad = 1'b1;
         else
            alloc_ok = 1'b1;
      end
      busy_nxt = busy & ~rel_ok;
      if (alloc_ok) busy_nxt[alloc_id] = 1'b1;
      a_alu = alloc_ok && (aid < CF_BASE);
      a_cf  = alloc_ok && (aid >= CF_BASE) && (aid < AGU_BASE);
      a_agu = alloc_ok && (aid >= AGU_BASE);
      rel_alu = 0;
      rel_cf  = 0;
      rel_agu = 0;
      for (int i = 0; i < NUM_ST; i++) begin
         if (rel_ok[i]) begin
            if (i < CF_BASE)       rel_alu = rel_alu + 1;
            else if (i < AGU_BASE) rel_cf  = rel_cf + 1;
            else                   rel_agu = rel_agu + 1;
         end
      end
      alu_cnt_nxt = ALU_CW'(int'(alu_free_cnt) + rel_alu - (a_alu ? 1 : 0));
      cf_cnt_nxt  = CF_CW'(int'(cf_free_cnt) + rel_cf - (a_cf ? 1 : 0));
      agu_cnt_nxt = AGU_CW'(int'(agu_free_cnt) + rel_agu - (a_agu ? 1 : 0));
   end

   // Occupancy, counters and sticky error; flush wins and suppresses errors for that cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy         <= '0;
         alu_free_cnt <= ALU_CW'(NUM_ALU);
         cf_free_cnt  <= CF_CW'(NUM_CF);
         agu_free_cnt <= AGU_CW'(NUM_AGU);
         alloc_err    <= 1'b0;
      end else if (flush) begin
         busy         <= '0;
         alu_free_cnt <= ALU_CW'(NUM_ALU);
         cf_free_cnt  <= CF_CW'(NUM_CF);
         agu_free_cnt <= AGU_CW'(NUM_AGU);
      end else begin
         busy         <= busy_nxt;
         alu_free_cnt <= alu_cnt_nxt;
         cf_free_cnt  <= cf_cnt_nxt;
         agu_free_cnt <= agu_cnt_nxt;
         if (rel_bad || alloc_bad) alloc_err <= 1'b1;
      end
   end

   assign available   = ~busy;
   assign alu_next_id = pick(~busy, 0, NUM_ALU, alu_start);
   assign cf_next_id  = pick(~busy, CF_BASE, NUM_CF, cf_start);
   assign agu_next_id = pick(~busy, AGU_BASE, NUM_AGU, agu_start);

endmodule

// File: tb/tb_rs_alloc_tracker.sv
// Directed bench for rs_alloc_tracker with default parameters (4 ALU, 2 CF, 4 AGU, invalid id 10).
// Inputs change 1ns after the rising edge; outputs are checked before the next edge.
// Expectations are hand-derived constants; round-robin build adjusts the few affected ids.
module tb_rs_alloc_tracker;
   logic       clk = 1'b0;
   logic       reset;
   logic       alloc_valid;
   logic [3:0] alloc_id;
   logic [9:0] release_mask;
   logic       flush;
   logic [9:0] available;
   logic [3:0] alu_next_id, cf_next_id, agu_next_id;
   logic [2:0] alu_free_cnt;
   logic [1:0] cf_free_cnt;
   logic [2:0] agu_free_cnt;
   logic       alloc_err;
   int         total = 0;
   int         bad = 0;

   rs_alloc_tracker dut (
      .clk(clk), .reset(reset), .alloc_valid(alloc_valid), .alloc_id(alloc_id),
      .release_mask(release_mask), .flush(flush), .available(available),
      .alu_next_id(alu_next_id), .cf_next_id(cf_next_id), .agu_next_id(agu_next_id),
      .alu_free_cnt(alu_free_cnt), .cf_free_cnt(cf_free_cnt), .agu_free_cnt(agu_free_cnt),
      .alloc_err(alloc_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic av, input logic [3:0] id, input logic [9:0] rm, input logic fl);
      alloc_valid  = av;
      alloc_id     = id;
      release_mask = rm;
      flush        = fl;
      @(posedge clk);
      #1;
      alloc_valid  = 1'b0;
      alloc_id     = 4'd0;
      release_mask = '0;
      flush        = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_avail"}, 32'(available), 32'h3FF);
      chk({tag, "_alu_cnt"}, 32'(alu_free_cnt), 4);
      chk({tag, "_cf_cnt"}, 32'(cf_free_cnt), 2);
      chk({tag, "_agu_cnt"}, 32'(agu_free_cnt), 4);
      chk({tag, "_alu_id"}, 32'(alu_next_id), 0);
      chk({tag, "_cf_id"}, 32'(cf_next_id), 4);
      chk({tag, "_agu_id"}, 32'(agu_next_id), 6);
   endtask

   initial begin
      reset = 1'b1;
      alloc_valid = 1'b0;
      alloc_id = 4'd0;
      release_mask = '0;
      flush = 1'b0;
      #12 reset = 1'b0;
      @(posedge clk);
      #1;
      // Reset / idle state
      chk_idle("rst");
      chk("rst_err", 32'(alloc_err), 0);

      // Fill the ALU class
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'(i), '0, 1'b0);
         chk($sformatf("fill%0d_cnt", i), 32'(alu_free_cnt), 32'(3 - i));
         chk($sformatf("fill%0d_id", i), 32'(alu_next_id), (i == 3) ? 32'd10 : 32'(i + 1));
      end
      chk("full_avail", 32'(available[3:0]), 0);

      // Release and re-alloc station 2 in one cycle
      step(1'b1, 4'd2, 10'b00_0000_0100, 1'b0);
      chk("relalloc_avail", 32'(available[3:0]), 0);
      chk("relalloc_cnt", 32'(alu_free_cnt), 0);
      chk("relalloc_err", 32'(alloc_err), 0);

      // Release only station 1, then re-allocate it
      step(1'b0, 4'd0, 10'b00_0000_0010, 1'b0);
      chk("rel1_avail", 32'(available), 32'h3F2);
      chk("rel1_cnt", 32'(alu_free_cnt), 1);
      chk("rel1_id", 32'(alu_next_id), 1);
      step(1'b1, 4'd1, '0, 1'b0);
      chk("realloc1_cnt", 32'(alu_free_cnt), 0);

      // AGU station 7 allocated twice
      step(1'b1, 4'd7, '0, 1'b0);
      chk("agu7_cnt", 32'(agu_free_cnt), 3);
      chk("agu7_avail", 32'(available[7]), 0);
`ifdef RS_RR_ALLOC_EN
      chk("agu7_id", 32'(agu_next_id), 8);
`else
      chk("agu7_id", 32'(agu_next_id), 6);
`endif
      chk("agu7_err", 32'(alloc_err), 0);
      step(1'b1, 4'd7, '0, 1'b0);
      chk("dup7_err", 32'(alloc_err), 1);
      chk("dup7_cnt", 32'(agu_free_cnt), 3);

      // CF alloc then flush with a concurrent alloc of 5
      step(1'b1, 4'd4, '0, 1'b0);
      chk("cf4_cnt", 32'(cf_free_cnt), 1);
      chk("cf4_id", 32'(cf_next_id), 5);
      step(1'b1, 4'd5, '0, 1'b1);
      chk_idle("flush");
      chk("flush_err_sticky", 32'(alloc_err), 1);

      // Asynchronous reset between clock edges
      step(1'b1, 4'd8, '0, 1'b0);
      chk("pre_arst_agu", 32'(agu_free_cnt), 3);
      reset = 1'b1;
      #1;
      chk("arst_avail", 32'(available), 32'h3FF);
      chk("arst_agu", 32'(agu_free_cnt), 4);
      chk("arst_err", 32'(alloc_err), 0);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // Release of an already-free station
      step(1'b0, 4'd0, 10'b00_0000_1000, 1'b0);
      chk("relfree_err", 32'(alloc_err), 1);
      chk_idle("relfree");
      pulse_reset();

      // Out-of-range alloc id
      step(1'b1, 4'd10, '0, 1'b0);
      chk("badid_err", 32'(alloc_err), 1);
      chk_idle("badid");
      pulse_reset();

      // Alloc then release station 0: next-id policy
      step(1'b1, 4'd0, '0, 1'b0);
      step(1'b0, 4'd0, 10'b00_0000_0001, 1'b0);
      chk("pol_avail", 32'(available), 32'h3FF);
`ifdef RS_RR_ALLOC_EN
      chk("pol_id", 32'(alu_next_id), 1);
`else
      chk("pol_id", 32'(alu_next_id), 0);
`endif
      chk("pol_err", 32'(alloc_err), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
